// File: rtl/front_panel_encoder.sv
// Front-panel input encoder: turns keypad scanner events and the raw door switch
// into timer/power/door/start/cancel commands for the microwave controller.
module front_panel_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       door_raw,
    input  logic       busy,
    output logic       power,
    output logic [6:0] timer,
    output logic       door_status,
    output logic       start_button,
    output logic       cancel_button,
    output logic [1:0] digit_count
);

    // State encoding doubles as the digit count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } entry_state_e;

    typedef enum logic [3:0] {
        KEY_POWER  = 4'd10,
        KEY_CLEAR  = 4'd11,
        KEY_START  = 4'd12,
        KEY_CANCEL = 4'd13
    } key_cmd_e;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    entry_state_e state_q, state_d;
    logic [3:0]   tens_q, tens_d;
    logic [3:0]   ones_q, ones_d;
    logic         power_q, power_d;
    logic         key_valid_q, key_valid_d;
    logic         door_status_q, door_status_d;
    logic [3:0]   db_cnt_q, db_cnt_d;
    logic         start_q, start_d;
    logic         cancel_q, cancel_d;
    logic         key_accept;

    assign key_accept = key_valid && !key_valid_q;

    // NOTE: every variable written here gets its hold value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        tens_d        = tens_q;
        ones_d        = ones_q;
        power_d       = power_q;
        key_valid_d   = key_valid;
        door_status_d = door_status_q;
        db_cnt_d      = 4'd0;
        start_d       = 1'b0;
        cancel_d      = 1'b0;

        if (key_accept) begin
            if (key_code <= 4'd9) begin
                if (!busy) begin
                    case (state_q)
                        EMPTY: begin
                            ones_d  = key_code;
                            tens_d  = 4'd0;
                            state_d = ONE;
                        end
                        ONE: begin
                            tens_d  = ones_q;
                            ones_d  = key_code;
                            state_d = TWO;
                        end
                        default: ;
                    endcase
                end
            end else begin
                case (key_code)
                    KEY_POWER: begin
                        if (!busy) power_d = !power_q;
                    end
                    KEY_CLEAR: begin
                        if (!busy) begin
                            tens_d  = 4'd0;
                            ones_d  = 4'd0;
                            state_d = EMPTY;
                        end
                    end
                    // Gated by the debounced door, never by the raw switch.
                    KEY_START: start_d = door_status_q;
                    KEY_CANCEL: begin
                        cancel_d = 1'b1;
                        tens_d   = 4'd0;
                        ones_d   = 4'd0;
                        state_d  = EMPTY;
                    end
                    default: ;
                endcase
            end
        end

        if (door_raw != door_status_q) begin
            if (db_cnt_q == DB_LAST) begin
                door_status_d = door_raw;
            end else begin
                db_cnt_d = db_cnt_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= EMPTY;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
            power_q       <= 1'b0;
            key_valid_q   <= 1'b0;
            door_status_q <= 1'b0;
            db_cnt_q      <= 4'd0;
            start_q       <= 1'b0;
            cancel_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            power_q       <= power_d;
            key_valid_q   <= key_valid_d;
            door_status_q <= door_status_d;
            db_cnt_q      <= db_cnt_d;
            start_q       <= start_d;
            cancel_q      <= cancel_d;
        end
    end

    assign timer         = ({3'b000, tens_q} * 7'd10) + {3'b000, ones_q};
    assign power         = power_q;
    assign door_status   = door_status_q;
    assign start_button  = start_q;
    assign cancel_button = cancel_q;
    assign digit_count   = state_q;

endmodule

// File: tb/tb_front_panel_encoder.sv
// Directed bench for front_panel_encoder: expected outputs are queued as each
// step is driven and compared after the following rising edge.
module tb_front_panel_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       door_raw;
    logic       busy;
    logic       power;
    logic [6:0] timer;
    logic       door_status;
    logic       start_button;
    logic       cancel_button;
    logic [1:0] digit_count;

    front_panel_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .door_raw      (door_raw),
        .busy          (busy),
        .power         (power),
        .timer         (timer),
        .door_status   (door_status),
        .start_button  (start_button),
        .cancel_button (cancel_button),
        .digit_count   (digit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] timer;
        logic [1:0] dc;
        logic       power;
        logic       door;
        logic       start;
        logic       cancel;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int checks = 0;
    int errors = 0;

    // Reference values for the next sampled edge, set explicitly by each step.
    logic [6:0] m_timer;
    logic [1:0] m_dc;
    logic       m_power, m_door, m_start, m_cancel;

    task automatic compare_front();
        exp_t  e;
        string t;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: got 0 entries, required 1");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (timer === e.timer) else begin
                errors++;
                $error("FAIL %s timer: got %0d required %0d", t, timer, e.timer);
            end
            checks++;
            assert (digit_count === e.dc) else begin
                errors++;
                $error("FAIL %s digit_count: got %0d required %0d", t, digit_count, e.dc);
            end
            checks++;
            assert (power === e.power) else begin
                errors++;
                $error("FAIL %s power: got %b required %b", t, power, e.power);
            end
            checks++;
            assert (door_status === e.door) else begin
                errors++;
                $error("FAIL %s door_status: got %b required %b", t, door_status, e.door);
            end
            checks++;
            assert (start_button === e.start) else begin
                errors++;
                $error("FAIL %s start_button: got %b required %b", t, start_button, e.start);
            end
            checks++;
            assert (cancel_button === e.cancel) else begin
                errors++;
                $error("FAIL %s cancel_button: got %b required %b", t, cancel_button, e.cancel);
            end
        end
    endtask

    task automatic tick_check(input string tag);
        exp_q.push_back('{timer: m_timer, dc: m_dc, power: m_power, door: m_door,
                          start: m_start, cancel: m_cancel});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    // Caller sets m_timer/m_dc/m_power first; pulses apply to the acceptance edge only.
    task automatic press(input logic [3:0] code, input logic exp_start,
                         input logic exp_cancel, input string tag);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        m_start   = exp_start;
        m_cancel  = exp_cancel;
        tick_check(tag);
        @(negedge clk);
        key_valid = 1'b0;
        m_start   = 1'b0;
        m_cancel  = 1'b0;
        tick_check({tag, "_rel"});
    endtask

    task automatic door_settle(input logic level, input string tag);
        @(negedge clk);
        door_raw = level;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) m_door = level;
            tick_check($sformatf("%s_%0d", tag, i));
            if (i < 4) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 4'd0; door_raw = 1'b0; busy = 1'b0;
        m_timer = 7'd0; m_dc = 2'd0; m_power = 1'b0; m_door = 1'b0;
        m_start = 1'b0; m_cancel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tick_check("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Digit entry: 4, 7, then a third digit that must be ignored.
        m_timer = 7'd4;  m_dc = 2'd1; press(4'd4, 1'b0, 1'b0, "digit_4");
        m_timer = 7'd47; m_dc = 2'd2; press(4'd7, 1'b0, 1'b0, "digit_47");
        press(4'd3, 1'b0, 1'b0, "digit_third_ignored");

        // CLEAR and POWER toggling.
        m_timer = 7'd0; m_dc = 2'd0; press(4'd11, 1'b0, 1'b0, "clear");
        m_power = 1'b1; press(4'd10, 1'b0, 1'b0, "power_on");
        m_power = 1'b0; press(4'd10, 1'b0, 1'b0, "power_off");

        // Entry locked while busy.
        busy = 1'b1;
        press(4'd5,  1'b0, 1'b0, "busy_digit");
        press(4'd10, 1'b0, 1'b0, "busy_power");
        busy = 1'b0;

        // Close the door: status follows exactly four edges later.
        door_settle(1'b1, "door_close");

        // START with door closed keeps the entry.
        m_timer = 7'd8; m_dc = 2'd1; press(4'd8, 1'b0, 1'b0, "digit_8");
        press(4'd12, 1'b1, 1'b0, "start_closed");

        // START with door open: no pulse, entry still retained.
        door_settle(1'b0, "door_open");
        press(4'd12, 1'b0, 1'b0, "start_open");

        // START held for 10 cycles yields a single pulse.
        door_settle(1'b1, "door_reclose");
        @(negedge clk);
        key_valid = 1'b1; key_code = 4'd12; m_start = 1'b1;
        tick_check("start_hold_1");
        m_start = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            tick_check($sformatf("start_hold_%0d", i));
        end
        @(negedge clk);
        key_valid = 1'b0;
        tick_check("start_hold_rel");

        // CANCEL while busy after entering 25, with power on.
        m_timer = 7'd0;  m_dc = 2'd0; press(4'd11, 1'b0, 1'b0, "clear_2");
        m_timer = 7'd2;  m_dc = 2'd1; press(4'd2, 1'b0, 1'b0, "digit_2");
        m_timer = 7'd25; m_dc = 2'd2; press(4'd5, 1'b0, 1'b0, "digit_25");
        m_power = 1'b1; press(4'd10, 1'b0, 1'b0, "power_on_2");
        busy = 1'b1;
        m_timer = 7'd0; m_dc = 2'd0; press(4'd13, 1'b0, 1'b1, "cancel_busy");
        busy = 1'b0;

        // Ignored code.
        m_timer = 7'd3; m_dc = 2'd1; press(4'd3, 1'b0, 1'b0, "digit_3");
        press(4'd14, 1'b0, 1'b0, "code_14");

        // Glitch of three cycles from an open door never propagates.
        door_settle(1'b0, "door_open_2");
        @(negedge clk);
        door_raw = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick_check($sformatf("glitch_hi_%0d", i));
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        door_raw = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick_check($sformatf("glitch_after_%0d", i));
            if (i < 5) @(negedge clk);
        end

        // Mid-entry, mid-debounce reset with key_valid held across release.
        m_timer = 7'd0; m_dc = 2'd0; press(4'd11, 1'b0, 1'b0, "clear_3");
        m_timer = 7'd9; m_dc = 2'd1; press(4'd9, 1'b0, 1'b0, "digit_9");
        @(negedge clk);
        door_raw = 1'b1;
        tick_check("debounce_mid_1");
        @(negedge clk);
        tick_check("debounce_mid_2");
        @(negedge clk);
        reset = 1'b1; door_raw = 1'b0; key_valid = 1'b1; key_code = 4'd6;
        m_timer = 7'd0; m_dc = 2'd0; m_power = 1'b0; m_door = 1'b0;
        tick_check("mid_reset");
        @(negedge clk);
        tick_check("mid_reset_hold");
        @(negedge clk);
        reset = 1'b0;
        m_timer = 7'd6; m_dc = 2'd1;
        tick_check("startup_accept");
        @(negedge clk);
        key_valid = 1'b0;
        tick_check("startup_rel");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/front_panel_encoder.md
# front_panel_encoder

Front-panel input encoder that drives the microwave controller's command inputs. It turns a raw keypad scanner stream and a raw door switch into the signals the controller consumes:
- a two-digit decimal `timer` value
- a latched `power` selection
- a debounced `door_status`
- single-cycle `start_button` / `cancel_button` pulses

It sits between the board's keypad/door pins and the controller, one per controller instance.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before door_status follows door_raw; legal range 1–15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- key_valid  input  1  level from keypad scanner; a key is taken on its 0→1 transition.
- key_code  input  4  0–9 digit, 10 POWER toggle, 11 CLEAR, 12 START, 13 CANCEL, 14–15 ignored.
- door_raw  input  1  undebounced door switch; 0 OPEN, 1 CLOSED.
- busy  input  1  high while the controller is cooking; locks entry.
- power  output  1  0 HALF, 1 FULL.
- timer  output  7  entered heat time in seconds, 0–99.
- door_status  output  1  debounced door; 0 OPEN, 1 CLOSED.
- start_button  output  1  one-cycle start pulse.
- cancel_button  output  1  one-cycle cancel pulse.
- digit_count  output  2  digits currently entered: 0, 1 or 2.

## Operation
**Key acceptance**
- A key is accepted on the edge where key_valid=1 and the registered previous sample of key_valid is 0.
- Holding key_valid high yields exactly one acceptance.
- The accepted key_code is the value sampled on that edge.

**Entry FSM** (states EMPTY, ONE, TWO; digits held as BCD `tens`, `ones`):
- Digit d in EMPTY: ones←d, tens←0 → ONE.
- Digit d in ONE: tens←ones, ones←d → TWO.
- Digit in TWO: ignored, no state change.
- CLEAR from any state: tens←0, ones←0 → EMPTY.
- timer = tens*10 + ones, computed combinationally from registers, 7-bit result. Maximum value 99.
- digit_count: EMPTY=0, ONE=1, TWO=2.

**POWER**: toggles `power`.

**busy=1**: digits, POWER and CLEAR are consumed (the edge is used) but have no effect. START and CANCEL still act.

**START**
- door_status=1: start_button=1 for exactly the cycle after acceptance.
- door_status=0: no pulse.
- Entry is retained.

**CANCEL**
- cancel_button=1 for exactly the cycle after acceptance, regardless of door or busy.
- Also clears the entry to EMPTY, timer 0.
- `power` is unchanged.

**Codes 14–15**: no effect.

**Door debounce**
- A 4-bit counter increments each cycle door_raw≠door_status.
- It clears whenever door_raw=door_status.
- When the counter reaches DEBOUNCE_CYCLES−1 while the mismatch persists, door_status takes door_raw on that edge and the counter clears.
- Result: a clean change on door_raw appears on door_status exactly DEBOUNCE_CYCLES edges later.
- A glitch shorter than DEBOUNCE_CYCLES cycles never propagates.

**Door open during entry**: entry, digit_count and power are retained.

## Timing
- Reset values: power 0, timer 0, digit_count 0, door_status 0, start_button 0, cancel_button 0. Debounce counter 0; key_valid history 0.
- A key_valid already high when reset deasserts is accepted on the first edge after reset. History is 0, so this counts as a rising edge.
- Reset asserted mid-entry or mid-debounce clears everything on that edge. No pulse is emitted on the reset edge.
- Key latency: effects (timer, power, digit_count, pulses) are visible one edge after acceptance, i.e. registered.
- Pulses never exceed one cycle. Back-to-back START keys need key_valid to drop, so pulses are separated by at least 2 cycles.
- START/door interaction: START is gated by the registered door_status on the acceptance edge, not by door_raw.
- Reading is combinational in `timer` only; all other outputs are direct flop outputs.

## Test plan
- **Reset and digit entry:** reset, then keys 4, 7, 3 → timer 4 then 47, digit_count 1 then 2; third digit ignored, timer stays 47.
- **CLEAR, POWER and lock:** CLEAR → timer 0, digit_count 0. POWER twice → power 1 then 0. With busy=1, key 5 and POWER → timer and power unchanged.
- **START pulses:** door_raw held 1 for DEBOUNCE_CYCLES cycles then START → start_button high exactly one cycle. Repeat with door open → no pulse. key_valid held high for 10 cycles → one pulse only.
- **CANCEL:** after entering 25 with busy=1, CANCEL → cancel_button one cycle, timer 0, digit_count 0, power unchanged.
- **Debounce:** with DEBOUNCE_CYCLES=4:
  - door_raw 0→1 glitch of 3 cycles → door_status stays 0.
  - Stable 1 → door_status rises exactly 4 edges after door_raw.
- **Mid-operation reset and startup acceptance:**
  - Reset asserted mid-debounce and after entry of 9 → all outputs return to reset values next edge.
  - key_valid high across reset release → key accepted on the first post-reset edge.
